instruction_loader: RTL and testbench

Writable instruction memory for the microprocessor, the write-side counterpart to the fixed test-instruction ROM. A host streams a program in byte by byte over a valid/ready handshake. The block holds the processor in reset while it loads, then releases it. It also answers the processor's `pc` with the stored `instruction` byte, so it replaces the hard-wired ROM in the top level.

---
 rtl/instruction_loader.sv | 165 ++++++++++++++++
 tb/tb_instruction_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Writable instruction memory: a host streams a program in over valid/ready while
// the processor is held in reset; the processor then fetches bytes by pc.
module instruction_loader #(
    parameter int unsigned DEPTH = 32
) (
    input  logic       origclk,
    input  logic       reset,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    output logic       load_done,
    output logic       load_error,
    output logic [7:0] load_count,
    output logic       cpu_reset,
    input  logic [7:0] pc,
    output logic [7:0] instruction
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_MAX = (DEPTH > 255) ? 255 : DEPTH;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] wptr;
    logic [7:0]    mem [DEPTH];

    logic          accept_c;
    logic          load_ready_d;
    logic          load_done_d;
    logic          load_error_d;
    logic          cpu_reset_d;

    // A restart request takes priority over a coincident byte, so the byte is dropped.
    assign accept_c = load_valid & load_ready & ~load_start & (state == S_LOAD);

    // State register
    always_ff @(posedge origclk) begin
        if (reset) begin
            state <= S_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_CLEAR: begin
                if (clr_ptr == LAST_IDX) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (load_start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_start) begin
                    state_next = S_LOAD;
                end else if (accept_c) begin
                    if (load_last) begin
                        state_next = S_RUN;
                    end else if (wptr == LAST_IDX) begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_RUN, S_ERROR: begin
                if (load_start) begin
                    state_next = S_LOAD;
                end
            end
            default: begin
                state_next = S_CLEAR;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track it
    always_comb begin
        load_ready_d = 1'b0;
        load_done_d  = 1'b0;
        load_error_d = 1'b0;
        cpu_reset_d  = 1'b1;
        case (state_next)
            S_LOAD: begin
                load_ready_d = 1'b1;
            end
            S_RUN: begin
                cpu_reset_d = 1'b0;
                load_done_d = (state == S_LOAD);
            end
            S_ERROR: begin
                load_error_d = 1'b1;
            end
            default: begin
                load_ready_d = 1'b0;
            end
        endcase
    end

    // Registered handshake/status outputs
    always_ff @(posedge origclk) begin
        if (reset) begin
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            cpu_reset  <= 1'b1;
        end else begin
            load_ready <= load_ready_d;
            load_done  <= load_done_d;
            load_error <= load_error_d;
            cpu_reset  <= cpu_reset_d;
        end
    end

    // Clear pointer, write pointer and saturating byte counter
    always_ff @(posedge origclk) begin
        if (reset) begin
            clr_ptr    <= '0;
            wptr       <= '0;
            load_count <= '0;
        end else begin
            if (state == S_CLEAR) begin
                clr_ptr <= clr_ptr + AW'(1);
            end
            if (load_start && (state != S_CLEAR)) begin
                wptr       <= '0;
                load_count <= '0;
            end else if (accept_c) begin
                wptr <= wptr + AW'(1);
                if (load_count < 8'(CNT_MAX)) begin
                    load_count <= load_count + 8'd1;
                end
            end
        end
    end

    // Single write port shared by the clear sweep and the load stream
    always_ff @(posedge origclk) begin
        if (state == S_CLEAR) begin
            mem[clr_ptr] <= 8'h00;
        end else if (accept_c) begin
            mem[wptr] <= load_data;
        end
    end

    // Fetch path reads the array as of the last edge; out-of-range pc reads zero.
    assign instruction = ({1'b0, pc} < 9'(DEPTH)) ? mem[pc[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized scoreboard bench for instruction_loader against a program-level
// model of the memory, the load session and the expected completion events.
module tb_instruction_loader;

    localparam int unsigned DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       load_done;
    logic       load_error;
    logic [7:0] load_count;
    logic       cpu_reset;
    logic [7:0] pc;
    logic [7:0] instruction;

    always #5 clk = ~clk;

    instruction_loader #(.DEPTH(DEPTH)) dut (
        .origclk     (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_error  (load_error),
        .load_count  (load_count),
        .cpu_reset   (cpu_reset),
        .pc          (pc),
        .instruction (instruction)
    );

    int checks = 0;
    int passed = 0;

    // Reference model
    logic [7:0] ref_mem [DEPTH];
    int         clr_left = 0;
    bit         mon_en   = 1'b0;
    bit         in_load  = 1'b0;
    int         wp       = 0;
    int         exp_cnt  = 0;
    bit         exp_ready     = 1'b0;
    bit         exp_cpu_reset = 1'b1;
    bit         exp_error     = 1'b0;
    int         done_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares DUT outputs with the model away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("cpu_reset", 32'(cpu_reset), 32'(exp_cpu_reset));
                chk("load_ready", 32'(load_ready), 32'(exp_ready));
                chk("load_error", 32'(load_error), 32'(exp_error));
                chk("load_count", 32'(load_count), 32'(exp_cnt));
                if (clr_left == 0)
                    chk("instruction", 32'(instruction),
                        (int'(pc) < DEPTH) ? 32'(ref_mem[pc]) : 32'h0);
                if (load_done === 1'b1) begin
                    chk("load_done_expected", 32'(done_q.size() > 0), 32'h1);
                    if (done_q.size() > 0)
                        chk("done_count", 32'(load_count), 32'(done_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (clr_left > 0) clr_left--;
    endtask

    task automatic rand_pc();
        pc = 8'($urandom_range(0, 47));
    endtask

    task automatic do_reset();
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0;
        clr_left = DEPTH + 1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;
        in_load = 1'b0; wp = 0; exp_cnt = 0;
        exp_ready = 1'b0; exp_cpu_reset = 1'b1; exp_error = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rand_pc();
            tick();
        end
    endtask

    task automatic start_load(input bit with_byte, input logic [7:0] d);
        bit was_clear;
        was_clear  = (clr_left > 0);
        load_start = 1'b1; load_valid = with_byte; load_data = d;
        load_last  = 1'($urandom_range(0, 1));
        rand_pc();
        tick();
        load_start = 1'b0; load_valid = 1'b0;
        if (!was_clear) begin
            in_load = 1'b1; wp = 0; exp_cnt = 0;
            exp_ready = 1'b1; exp_cpu_reset = 1'b1; exp_error = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit last, input bit valid);
        load_valid = valid; load_data = d; load_last = last;
        rand_pc();
        tick();
        load_valid = 1'b0;
        if (valid && in_load) begin
            ref_mem[wp] = d;
            wp++;
            if (exp_cnt < int'(DEPTH)) exp_cnt++;
            if (last) begin
                in_load = 1'b0; exp_ready = 1'b0; exp_cpu_reset = 1'b0;
                done_q.push_back(exp_cnt);
            end else if (wp == int'(DEPTH)) begin
                in_load = 1'b0; exp_ready = 1'b0; exp_error = 1'b1;
            end
        end
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            pc = 8'(i);
            tick();
        end
    endtask

    logic [7:0] prog [4];
    int len, acc, guard;
    bit v;

    initial begin
        prog[0] = 8'h44; prog[1] = 8'h49; prog[2] = 8'h19; prog[3] = 8'h84;
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0;
        load_data = 8'h00; load_last = 1'b0; pc = 8'h00;
        repeat (2) @(posedge clk);

        // Clear phase: a start request in the final clear cycle must be ignored
        do_reset();
        idle(DEPTH - 1);
        start_load(1'b0, 8'h00);
        sweep(DEPTH);

        // Basic four-byte program
        start_load(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) send(prog[i], i == 3, 1'b1);
        sweep(5);

        // Same program with valid gaps
        start_load(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            send(prog[i], i == 3, 1'b1);
            if (i < 3) begin
                send(8'($urandom), 1'b1, 1'b0);
                send(8'($urandom), 1'b1, 1'b0);
            end
        end
        sweep(5);

        // Overflow, ignored traffic in ERROR, then a clean two-byte reload
        start_load(1'b0, 8'h00);
        for (int i = 0; i < int'(DEPTH); i++) send(8'($urandom), 1'b0, 1'b1);
        send(8'hAA, 1'b1, 1'b1);
        idle(3);
        start_load(1'b0, 8'h00);
        send(8'h5A, 1'b0, 1'b1);
        send(8'hA5, 1'b1, 1'b1);
        sweep(DEPTH);

        // Restart colliding with a handshake drops the byte
        start_load(1'b0, 8'h00);
        send(8'h11, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        start_load(1'b1, 8'hC3);
        send(8'h77, 1'b1, 1'b1);
        sweep(4);

        // Out-of-range fetch while running
        pc = 8'd40;
        tick();
        chk("pc40_reads_zero", 32'(instruction), 32'h0);

        // Reset in the middle of a load re-runs the clear sweep
        start_load(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1'b1);
        do_reset();
        idle(DEPTH);
        sweep(DEPTH);

        // Randomized sessions with gaps, restarts and overflows
        for (int it = 0; it < 25; it++) begin
            start_load(1'b0, 8'h00);
            len = $urandom_range(1, DEPTH + 4);
            acc = 0; guard = 0;
            while (in_load && guard < 500) begin
                guard++;
                if ($urandom_range(0, 19) == 0) begin
                    start_load(1'b1, 8'($urandom));
                    acc = 0;
                end else begin
                    v = ($urandom_range(0, 9) < 7);
                    send(8'($urandom), acc == len - 1, v);
                    if (v) acc++;
                end
            end
            for (int k = 0; k < int'($urandom_range(0, 4)); k++)
                send(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            sweep(DEPTH);
        end

        idle(2);
        chk("done_queue_drained", 32'(done_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
